jk_stream_gen: RTL and testbench
================================

# jk_stream_gen

Dual-channel unary bitstream generator that feeds the J and K inputs of the JK flip-flop division/sqrt kernel. It latches two unsigned binary operands and emits two bitstreams over a window of 2^WIDTH valid cycles. J carries rate a/2^WIDTH from an up-counter source. K carries rate b/2^WIDTH from the bit-reversed counter, which keeps the two streams decorrelated. Operation is deterministic and the one-counts are exact, so downstream results are bit-reproducible.

## Interface
- WIDTH, 8, operand width; window length N = 2^WIDTH cycles
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a new window; sampled only when ready=1
- a_in  in  WIDTH  J-channel operand, unsigned
- b_in  in  WIDTH  K-channel operand, unsigned
- hold  in  1  pause generation; no cnt advance, no output update other than valid
- ready  out  1  combinational, high when in IDLE
- busy  out  1  combinational, high when in RUN (equals ~ready)
- J  out  1  registered J bitstream bit
- K  out  1  registered K bitstream bit
- valid  out  1  registered; J/K meaningful this cycle
- last  out  1  registered; high with the final valid bit of a window

## Operation
- States: IDLE, RUN.
- Reset values: state=IDLE, cnt=0, a_reg=0, b_reg=0, J=0, K=0, valid=0, last=0.
- IDLE: on an edge with start=1:
  - a_reg<=a_in, b_reg<=b_in, cnt<=0, state<=RUN.
  - a_in and b_in are sampled only at this edge.
- RUN, edge with hold=0:
  - J<=(a_reg>cnt), K<=(b_reg>bitrev(cnt)), valid<=1, last<=(cnt==N-1).
  - cnt<=cnt+1, wrapping to 0 modulo N.
  - If cnt==N-1, state<=IDLE.
- RUN, edge with hold=1: valid<=0, last<=0; cnt, J, K and state hold.
- Any edge in IDLE: valid<=0, last<=0; J and K hold their last value.
- Comparisons are unsigned, WIDTH bits. bitrev maps bit i to bit WIDTH-1-i.
- Per completed window:
  - Exactly a ones on J and b ones on K.
  - a=0 gives all zeros.
  - Maximum a=N-1 gives N-1 ones; J=0 only on the last bit.
- start while busy: ignored. No queueing, no effect on the current window.
- Reset asserted mid-window: all state returns to reset values immediately. The partial window is discarded, with no last pulse.

## Timing
- Accept edge E0: start=1 and ready=1.
- First valid bit is visible after E1, i.e. 2 edges from start being sampled when hold=0.
- A window without hold occupies edges E1..EN. last is visible after EN, and ready rises in the same cycle.
- Next accept is at the earliest at EN+1. The first bit of that window appears after EN+2. This gives one cycle of valid=0 between back-to-back windows.
- hold adds exactly one cycle of latency per held edge. Bit order and bit values are unchanged.
- ready/busy depend on state only, with no combinational path from start.

## Structure
- Package ubit_pkg:
  - typedef enum {IDLE, RUN} gen_state_t.
  - Function bitrev parameterized by WIDTH.
  - No other constants.
- One sub-module, ubit_cnt_src: the WIDTH-bit window counter with enable and clear. It outputs cnt, bitrev(cnt) and a wrap flag (cnt==N-1).
- Top level holds the FSM, operand registers, comparators and output flops.

## Test plan
- WIDTH=8, a=200, b=64, hold=0:
  - Exactly 256 valid cycles with no gaps.
  - J ones=200, K ones=64.
  - last high only on the 256th valid cycle.
  - ready returns the same cycle.
- a=0, b=128:
  - J=0 on all valid cycles.
  - K sequence starts 1,0,1,0,… (cnt=0 → bitrev 0; cnt=1 → bitrev 128), with 128 ones total.
- a=255:
  - 255 ones on J.
  - J=0 only in the cycle where last=1.
- hold toggled pseudo-randomly (~30%) during a=77, b=150:
  - The valid-filtered bitstreams are identical to the hold=0 run.
  - valid=0 in every cycle following a held edge.
- start pulsed at cycles 10 and 100 of a running window with different operands:
  - Window completes with the original counts.
  - Second operands are not used.
  - One bubble before a subsequently accepted start.
- rst_n asserted at valid cycle 40:
  - All outputs 0 asynchronously, no last, ready=1 after release.
  - A new start yields a correct full window.

Source files
------------

// File: rtl/ubit_pkg.sv
// Shared types and helpers for the unary bitstream generator.
package ubit_pkg;

  typedef enum logic {IDLE, RUN} gen_state_t;

  // Reverses the low `width` bits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[width-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_stream_gen_if.sv
// Handshake, operand and bitstream signals of jk_stream_gen.
interface jk_stream_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             hold;
  logic             ready;
  logic             busy;
  logic             J;
  logic             K;
  logic             valid;
  logic             last;

  modport master (
    output start, a_in, b_in, hold,
    input  ready, busy, J, K, valid, last
  );

  modport slave (
    input  start, a_in, b_in, hold,
    output ready, busy, J, K, valid, last
  );
endinterface

// File: rtl/ubit_cnt_src.sv
// Window counter: free-running up-count with enable and clear, plus its bit-reversed view.
module ubit_cnt_src
  import ubit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_rev_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_rev_o = WIDTH'(bitrev(32'(cnt_q), WIDTH));
  assign wrap_o    = &cnt_q;

endmodule

// File: rtl/jk_stream_gen.sv
// Dual-channel unary bitstream generator: J rate a/2^WIDTH from the up-count,
// K rate b/2^WIDTH from the bit-reversed count, over one 2^WIDTH-cycle window.
module jk_stream_gen
  import ubit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  jk_stream_gen_if.slave  bus
);

  gen_state_t       state_d, state_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic             j_d, j_q, k_d, k_q;
  logic             valid_d, valid_q, last_d, last_q;

  logic [WIDTH-1:0] cnt, cnt_rev;
  logic             wrap, cnt_en, cnt_clr;
  logic             ready, busy;

  ubit_cnt_src #(
    .WIDTH (WIDTH)
  ) u_cnt_src (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .cnt_o     (cnt),
    .cnt_rev_o (cnt_rev),
    .wrap_o    (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (!bus.hold && wrap) state_d = IDLE;
    endcase
  end

  // Status and counter control depend on state only, never combinationally on start->ready.
  always_comb begin
    ready   = (state_q == IDLE);
    busy    = (state_q == RUN);
    cnt_clr = ready && bus.start;
    cnt_en  = busy && !bus.hold;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    j_d     = j_q;
    k_d     = k_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (cnt_clr) begin
      a_d = bus.a_in;
      b_d = bus.b_in;
    end
    if (cnt_en) begin
      j_d     = (a_q > cnt);
      k_d     = (b_q > cnt_rev);
      valid_d = 1'b1;
      last_d  = wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      j_q     <= j_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.J     = j_q;
  assign bus.K     = k_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;

endmodule

// File: tb/tb_jk_stream_gen.sv
// Directed bench for jk_stream_gen: expected bits are queued at start and checked as they emerge.
module tb_jk_stream_gen;

  localparam int unsigned W = 8;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_stream_gen_if #(.WIDTH(W)) bus ();

  jk_stream_gen #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];  // {J, K, last}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic push_window(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      logic [7:0] c;
      c = 8'(i);
      sb.push_back({a > c, b > tb_rev(c), i == N - 1});
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the accept edge.
  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    check("ready_before_start", 32'(bus.ready), 1);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    push_window(a, b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = 8'hA5;
    bus.b_in  = 8'h5A;
    check("valid_after_accept", 32'(bus.valid), 0);
    check("busy_after_accept", 32'(bus.busy), 1);
  endtask

  task automatic run_window(input int hold_pct, input bit inject, input int rst_at,
                            output int nvalid, output int jo, output int ko);
    int cyc;
    bit held;
    logic [2:0] e;
    cyc = 0;
    held = 1'b0;
    nvalid = 0;
    jo = 0;
    ko = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        check("window_timeout", 32'(sb.size()), 0);
        sb.delete();
        break;
      end
      if (held) check("valid_after_hold", 32'(bus.valid), 0);
      else if (hold_pct == 0) check("no_gap", 32'(bus.valid), 1);
      if (bus.valid) begin
        e = sb.pop_front();
        check("J", 32'(bus.J), 32'(e[2]));
        check("K", 32'(bus.K), 32'(e[1]));
        check("last", 32'(bus.last), 32'(e[0]));
        nvalid++;
        jo += bus.J ? 1 : 0;
        ko += bus.K ? 1 : 0;
        if (e[0]) check("ready_with_last", 32'(bus.ready), 1);
        else check("busy_mid_window", 32'(bus.busy), 1);
      end
      if (rst_at != 0 && nvalid == rst_at) break;
      if (inject && bus.valid && (nvalid == 10 || nvalid == 100)) begin
        bus.start = 1'b1;
        bus.a_in  = (nvalid == 10) ? 8'd250 : 8'd1;
        bus.b_in  = (nvalid == 10) ? 8'd5 : 8'd240;
      end else begin
        bus.start = 1'b0;
      end
      bus.hold = (sb.size() != 0) && (int'($urandom_range(99)) < hold_pct);
      held = bus.hold;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic full_window(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input int hold_pct, input bit inject);
    int nv, jo, ko;
    do_start(a, b);
    run_window(hold_pct, inject, 0, nv, jo, ko);
    check({tag, "_nvalid"}, 32'(nv), N);
    check({tag, "_j_ones"}, 32'(jo), 32'(a));
    check({tag, "_k_ones"}, 32'(ko), 32'(b));
  endtask

  initial begin
    int nv, jo, ko;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.hold  = 1'b0;
    #12;
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_J", 32'(bus.J), 0);
    check("rst_K", 32'(bus.K), 0);
    check("rst_last", 32'(bus.last), 0);
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    full_window("w200_64", 8'd200, 8'd64, 0, 1'b0);
    @(negedge clk);
    check("bubble_valid", 32'(bus.valid), 0);
    check("bubble_last", 32'(bus.last), 0);
    check("idle_J_holds", 32'(bus.J), 0);

    full_window("w0_128", 8'd0, 8'd128, 0, 1'b0);
    @(negedge clk);
    full_window("w255_1", 8'd255, 8'd1, 0, 1'b0);
    @(negedge clk);
    full_window("hold77_150", 8'd77, 8'd150, 30, 1'b0);
    @(negedge clk);
    full_window("inj33_210", 8'd33, 8'd210, 0, 1'b1);
    // Back-to-back: accept on the edge right after the last bit.
    full_window("b2b100_3", 8'd100, 8'd3, 0, 1'b0);
    @(negedge clk);

    do_start(8'd123, 8'd45);
    run_window(0, 1'b0, 40, nv, jo, ko);
    check("rst_mid_nvalid", 32'(nv), 40);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid), 0);
    check("arst_J", 32'(bus.J), 0);
    check("arst_K", 32'(bus.K), 0);
    check("arst_last", 32'(bus.last), 0);
    check("arst_ready", 32'(bus.ready), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_last", 32'(bus.last), 0);
    check("post_rst_valid", 32'(bus.valid), 0);
    check("post_rst_ready", 32'(bus.ready), 1);
    full_window("after_rst9_250", 8'd9, 8'd250, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
